muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit for the datapath. It is the sequential,

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_unit_div_step.sv | 20 ++
 rtl/muldiv_unit.sv | 212 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and operation encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_ENC_MULU = 2'b00;
    localparam logic [1:0] OP_ENC_MUL  = 2'b01;
    localparam logic [1:0] OP_ENC_DIVU = 2'b10;
    localparam logic [1:0] OP_ENC_DIV  = 2'b11;

    typedef enum logic [1:0] {
        MULU = OP_ENC_MULU,
        MUL  = OP_ENC_MUL,
        DIVU = OP_ENC_DIVU,
        DIV  = OP_ENC_DIV
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Upper encoding bit selects the divider, lower bit selects signed arithmetic.
    function automatic logic op_is_div(input op_e op);
        logic [1:0] enc;
        enc = op;
        return enc[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        logic [1:0] enc;
        enc = op;
        return enc[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module restoring_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] new_rem,
    output logic             q_bit
);
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] diff_s;

    // A set top bit means the shifted remainder already exceeds any WIDTH-bit divisor.
    assign shifted_s = {rem, dividend_bit};
    assign diff_s    = shifted_s[WIDTH-1:0] - divisor;
    assign q_bit     = shifted_s[WIDTH] | (shifted_s[WIDTH-1:0] >= divisor);
    assign new_rem   = q_bit ? diff_s : shifted_s[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one operand bit per cycle, 2*WIDTH result in HI/LO.
// Divider datapath is built only when MULDIV_DIV_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_dbz
);
    localparam int             CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_r, state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc_r, acc_next_s, mul_next_s, prod_fix_s;
    logic [WIDTH-1:0]   opnd_r;
    logic [WIDTH:0]     mul_sum_s;
    logic               neg_lo_r;
    logic               start_s, last_s, res_we_s;
    logic [WIDTH-1:0]   res_hi_s, res_lo_s;
    op_e                start_op_s;
    logic               start_div_s, start_signed_s;
    logic [WIDTH-1:0]   abs_a_s, abs_b_s;

    assign start_op_s     = op_e'(i_op);
    assign start_div_s    = op_is_div(start_op_s);
    assign start_signed_s = op_is_signed(start_op_s);
    assign abs_a_s        = (start_signed_s && i_a[WIDTH-1]) ? -i_a : i_a;
    assign abs_b_s        = (start_signed_s && i_b[WIDTH-1]) ? -i_b : i_b;
    assign start_s        = (state_r == IDLE) && i_start;
    assign last_s         = (state_r == RUN) && (cnt_r == LAST_CNT);

    // Next-state logic for the IDLE -> RUN -> DONE sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
`ifdef MULDIV_DIV_EN
                    state_next_s = RUN;
`else
                    state_next_s = start_div_s ? DONE : RUN;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register and handshake outputs, both derived from the current state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            o_busy  <= (state_r == RUN);
            o_done  <= (state_r == DONE);
        end
    end

    // Shift-add step: {hi,lo} holds the partial product with the multiplier in lo
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end

    assign prod_fix_s = neg_lo_r ? -acc_next_s : acc_next_s;

    // Operand latch at start, one iteration per RUN cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            neg_lo_r <= 1'b0;
        end else if (start_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            neg_lo_r <= start_signed_s && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            if (start_div_s) begin
                acc_r  <= {{WIDTH{1'b0}}, abs_a_s};
                opnd_r <= abs_b_s;
            end else begin
                acc_r  <= {{WIDTH{1'b0}}, abs_b_s};
                opnd_r <= abs_a_s;
            end
        end else if (state_r == RUN) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

`ifdef MULDIV_DIV_EN
    op_e                op_r;
    logic               neg_hi_r, dbz_r;
    logic [WIDTH-1:0]   div_rem_s, quo_fix_s, rem_fix_s;
    logic               div_q_s;
    logic [2*WIDTH-1:0] div_next_s;

    // Divide shares the accumulator: remainder in hi, dividend shifting out of lo
    restoring_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem          (acc_r[2*WIDTH-1:WIDTH]),
        .dividend_bit (acc_r[WIDTH-1]),
        .divisor      (opnd_r),
        .new_rem      (div_rem_s),
        .q_bit        (div_q_s)
    );

    assign div_next_s = {div_rem_s, acc_r[WIDTH-2:0], div_q_s};
    assign acc_next_s = op_is_div(op_r) ? div_next_s : mul_next_s;
    assign quo_fix_s  = neg_lo_r ? -acc_next_s[WIDTH-1:0] : acc_next_s[WIDTH-1:0];
    assign rem_fix_s  = neg_hi_r ? -acc_next_s[2*WIDTH-1:WIDTH] : acc_next_s[2*WIDTH-1:WIDTH];
    assign res_we_s   = last_s;

    // Final result select; a zero divisor leaves the dividend as remainder
    always_comb begin
        res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_fix_s[WIDTH-1:0];
        if (op_is_div(op_r)) begin
            res_hi_s = rem_fix_s;
            if (dbz_r) begin
                res_lo_s = {WIDTH{1'b1}};
            end else begin
                res_lo_s = quo_fix_s;
            end
        end else begin
            res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Divide-only operation attributes captured at start
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_r     <= MULU;
            neg_hi_r <= 1'b0;
            dbz_r    <= 1'b0;
        end else if (start_s) begin
            op_r     <= start_op_s;
            neg_hi_r <= start_signed_s && i_a[WIDTH-1];
            dbz_r    <= start_div_s && (i_b == {WIDTH{1'b0}});
        end
    end

    // Divide-by-zero flag follows each completed operation
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_dbz <= 1'b0;
        end else if (res_we_s) begin
            o_dbz <= dbz_r;
        end
    end
`else
    assign acc_next_s = mul_next_s;
    assign res_we_s   = last_s || (start_s && start_div_s);
    assign o_dbz      = 1'b0;

    // Divide requests complete straight from IDLE with a zero result
    always_comb begin
        res_hi_s = {WIDTH{1'b0}};
        res_lo_s = {WIDTH{1'b0}};
        if (state_r == IDLE) begin
            res_hi_s = {WIDTH{1'b0}};
            res_lo_s = {WIDTH{1'b0}};
        end else begin
            res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end
`endif

    // HI/LO hold their value until the next operation completes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_hi <= {WIDTH{1'b0}};
            o_lo <= {WIDTH{1'b0}};
        end else if (res_we_s) begin
            o_hi <= res_hi_s;
            o_lo <= res_lo_s;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32); honours MULDIV_DIV_EN.
module tb_muldiv_unit;
    localparam int W = 32;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, dbz;
    logic [W-1:0] hi, lo;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo),
        .o_dbz   (dbz)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op at edge 0, scramble inputs, optionally poke i_start at poke_edge,
    // then check latency, busy window, results and absence of extra done pulses.
    task automatic run_op(input string tag, input logic [1:0] t_op,
                          input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                          input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                          input logic e_dbz, input int e_done, input int e_busy,
                          input int poke_edge, input int watch);
        int done_edge  = 0;
        int busy_cnt   = 0;
        int busy_first = 0;
        int extra_done = 0;
        @(negedge clk);
        op = t_op; a = t_a; b = t_b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~t_op; a = ~t_a; b = t_b ^ 32'h0000_0005;
        for (int n = 1; n <= 60 && done_edge == 0; n++) begin
            if (n == poke_edge) begin
                start = 1'b1; op = 2'b00; a = 32'h0000_0009; b = 32'h0000_0009;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (busy && busy_first == 0) busy_first = n;
            if (busy) busy_cnt++;
            if (done) done_edge = n;
        end
        check({tag, "/latency"}, 64'(done_edge), 64'(e_done));
        check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(e_busy));
        check({tag, "/busy_first"}, 64'(busy_first), 64'((e_busy > 0) ? 1 : 0));
        check({tag, "/hi"}, 64'(hi), 64'(e_hi));
        check({tag, "/lo"}, 64'(lo), 64'(e_lo));
        check({tag, "/dbz"}, 64'(dbz), 64'(e_dbz));
        for (int k = 0; k < watch; k++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        check({tag, "/extra_done"}, 64'(extra_done), 64'd0);
        check({tag, "/hi_hold"}, 64'(hi), 64'(e_hi));
    endtask

    initial begin
        int late_done;
        int div_lat;
        int div_busy;
        div_lat  = DIV_ON ? 33 : 1;
        div_busy = DIV_ON ? 32 : 0;

        // reset state, with a start request held during reset
        #3 rst = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/hi", 64'(hi), 64'd0);
        check("reset/lo", 64'(lo), 64'd0);
        check("reset/dbz", 64'(dbz), 64'd0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1. unsigned max * max
        run_op("mulu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 32, 0, 2);
        // 2. signed multiply
        run_op("mul_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'h0000_0005,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33, 32, 0, 1);
        run_op("mul_0xm1", 2'b01, 32'h0000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h0000_0000, 1'b0, 33, 32, 0, 1);
        // 3. divides
        run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002,
               DIV_ON ? 32'hFFFF_FFFF : 32'h0, DIV_ON ? 32'hFFFF_FFFD : 32'h0,
               1'b0, div_lat, div_busy, 0, 1);
        run_op("divu_7d2", 2'b10, 32'h0000_0007, 32'h0000_0002,
               DIV_ON ? 32'h0000_0001 : 32'h0, DIV_ON ? 32'h0000_0003 : 32'h0,
               1'b0, div_lat, div_busy, 0, 1);
        // 4. divide by zero, then MIN / -1 clears the flag
        run_op("divu_dbz", 2'b10, 32'h0000_000A, 32'h0000_0000,
               DIV_ON ? 32'h0000_000A : 32'h0, DIV_ON ? 32'hFFFF_FFFF : 32'h0,
               DIV_ON, div_lat, div_busy, 0, 1);
        run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, DIV_ON ? 32'h8000_0000 : 32'h0,
               1'b0, div_lat, div_busy, 0, 1);
        // 5. start pulsed mid-run is ignored and not queued
        run_op("mulu_poke", 2'b00, 32'hFFFF_FFFF, 32'h0000_0003,
               32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33, 32, 10, 40);

        // 6. asynchronous reset during a run
        @(negedge clk);
        op = 2'b01; a = 32'hFFFF_FFFD; b = 32'h0000_0005; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("rst_run/busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_run/busy", 64'(busy), 64'd0);
        check("rst_run/hi", 64'(hi), 64'd0);
        check("rst_run/lo", 64'(lo), 64'd0);
        check("rst_run/done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        late_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) late_done++;
        end
        check("rst_run/no_done", 64'(late_done), 64'd0);
        run_op("mulu_6x7", 2'b00, 32'h0000_0006, 32'h0000_0007,
               32'h0000_0000, 32'h0000_002A, 1'b0, 33, 32, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
